// File: rtl/seq_cnt_sched_pkg.sv
// Shared definitions for the sequence-counter scheduler: counter width,
// controller state encoding and the counter's next-state table.
package seq_cnt_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Next value of the custom counter: main loop 0-6-4-7-3-0, strays 1->6, 2->7, 5->2.
  function automatic logic [CNT_W-1:0] seq_next(input logic [CNT_W-1:0] q);
    logic [CNT_W-1:0] n;
    case (q)
      3'd0:    n = 3'd6;
      3'd1:    n = 3'd6;
      3'd2:    n = 3'd7;
      3'd3:    n = 3'd0;
      3'd4:    n = 3'd7;
      3'd5:    n = 3'd2;
      3'd6:    n = 3'd4;
      3'd7:    n = 3'd3;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_cnt_sched_if.sv
// Requester-side bus of the sequence-counter scheduler: level requests with
// packed per-requester start/steps, one-hot grant, done pulse and result.
interface seq_cnt_sched_if
  import seq_cnt_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int STEP_W = 4
);

  logic [NREQ-1:0]        req;
  logic [NREQ*CNT_W-1:0]  start;
  logic [NREQ*STEP_W-1:0] steps;
  logic [NREQ-1:0]        gnt;
  logic                   done;
  logic [CNT_W-1:0]       result;

  modport master (output req, start, steps, input gnt, done, result);
  modport slave  (input req, start, steps, output gnt, done, result);

endinterface

// File: rtl/seq_cnt_sched_rr_arbiter.sv
// Round-robin arbiter: first requesting index at or after the pointer,
// wrapping modulo NREQ. Output is only non-zero while the update strobe is high.
module rr_arbiter
  import seq_cnt_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_upd,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [IDX_W:0] NREQ_L = (IDX_W+1)'(NREQ);

  logic           w_found;
  logic [IDX_W:0] w_sum;

  // Scan from the pointer upward and take the first live request.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= NREQ_L) w_sum = w_sum - NREQ_L;
      if (i_upd && !w_found && i_req[w_sum[IDX_W-1:0]]) begin
        w_found                   = 1'b1;
        o_gnt[w_sum[IDX_W-1:0]]   = 1'b1;
        o_idx                     = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_cnt_sched.sv
// Scheduler for the shared 3-bit custom-sequence counter. Grants jobs
// round-robin, loads the start value through the counter's asynchronous
// clear/preset, lets it run for the requested number of clocks, freezes it
// and returns the final value. cnt_en/cnt_value come straight from flops so
// the counter's async pins never see combinational glitches.
// Optional build macro SEQ_CHECK_EN: compares cnt_q against the shadow
// prediction in RUN/DONE and raises sticky seq_err on divergence.
//
//   state | meaning
//   IDLE  | counter frozen at last result, waiting for a request
//   LOAD  | counter held at the granted job's start value
//   RUN   | counter free-running, one advance per clock
//   DONE  | counter frozen at final value, done pulse, result valid
module seq_cnt_sched
  import seq_cnt_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int STEP_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  seq_cnt_sched_if.slave   bus,
  output logic             cnt_en,
  output logic [CNT_W-1:0] cnt_value,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             seq_err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              r_state,     w_state_nxt;
  logic [NREQ-1:0]     r_gnt,       w_gnt_nxt;
  logic                r_done,      w_done_nxt;
  logic [CNT_W-1:0]    r_result,    w_result_nxt;
  logic                r_cnt_en,    w_cnt_en_nxt;
  logic [CNT_W-1:0]    r_cnt_value, w_cnt_value_nxt;
  logic [IDX_W-1:0]    r_ptr,       w_ptr_nxt;
  logic [STEP_W-1:0]   r_rem,       w_rem_nxt;
  logic [CNT_W-1:0]    r_shadow,    w_shadow_nxt;
  logic [CNT_W-1:0]    r_hold,      w_hold_nxt;
  logic [STEP_W-1:0]   r_steps,     w_steps_nxt;

  logic [NREQ-1:0]     w_arb_gnt;
  logic [IDX_W-1:0]    w_arb_idx;
  logic [IDX_W-1:0]    w_ptr_inc;
  logic [CNT_W-1:0]    w_start_sel;
  logic [STEP_W-1:0]   w_steps_sel;
  logic [CNT_W-1:0]    w_shadow_adv;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .i_upd (r_state == IDLE),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_ptr_inc    = (w_arb_idx == IDX_W'(NREQ-1)) ? '0 : w_arb_idx + IDX_W'(1);
  assign w_shadow_adv = seq_next(r_shadow);

  // Pick the winner's start/steps slot out of the packed request bus.
  always_comb begin
    w_start_sel = '0;
    w_steps_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_start_sel = bus.start[CNT_W*i +: CNT_W];
        w_steps_sel = bus.steps[STEP_W*i +: STEP_W];
      end
    end
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_done_nxt      = 1'b0;
    w_result_nxt    = r_result;
    w_cnt_en_nxt    = r_cnt_en;
    w_cnt_value_nxt = r_cnt_value;
    w_ptr_nxt       = r_ptr;
    w_rem_nxt       = r_rem;
    w_shadow_nxt    = r_shadow;
    w_hold_nxt      = r_hold;
    w_steps_nxt     = r_steps;
    case (r_state)
      IDLE: begin
        w_cnt_en_nxt    = 1'b1;
        w_cnt_value_nxt = r_hold;
        if (|w_arb_gnt) begin
          w_state_nxt     = LOAD;
          w_gnt_nxt       = w_arb_gnt;
          w_shadow_nxt    = w_start_sel;
          w_cnt_value_nxt = w_start_sel;
          w_steps_nxt     = w_steps_sel;
          w_ptr_nxt       = w_ptr_inc;
        end
      end
      LOAD: begin
        w_rem_nxt = r_steps;
        if (r_steps == '0) begin
          w_state_nxt  = DONE;
          w_done_nxt   = 1'b1;
          w_result_nxt = r_cnt_value;
        end else begin
          w_state_nxt  = RUN;
          w_cnt_en_nxt = 1'b0;
        end
      end
      RUN: begin
        w_shadow_nxt = w_shadow_adv;
        w_rem_nxt    = r_rem - STEP_W'(1);
        // Re-assert the preset on the same edge as the counter's last advance.
        if (r_rem == STEP_W'(1)) begin
          w_state_nxt     = DONE;
          w_cnt_en_nxt    = 1'b1;
          w_cnt_value_nxt = w_shadow_adv;
          w_done_nxt      = 1'b1;
          w_result_nxt    = w_shadow_adv;
        end
      end
      DONE: begin
        w_hold_nxt  = r_cnt_value;
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset parks the counter at 0.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_cnt_en    <= 1'b1;
      r_cnt_value <= '0;
      r_ptr       <= '0;
      r_rem       <= '0;
      r_shadow    <= '0;
      r_hold      <= '0;
      r_steps     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_done      <= w_done_nxt;
      r_result    <= w_result_nxt;
      r_cnt_en    <= w_cnt_en_nxt;
      r_cnt_value <= w_cnt_value_nxt;
      r_ptr       <= w_ptr_nxt;
      r_rem       <= w_rem_nxt;
      r_shadow    <= w_shadow_nxt;
      r_hold      <= w_hold_nxt;
      r_steps     <= w_steps_nxt;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign cnt_en     = r_cnt_en;
  assign cnt_value  = r_cnt_value;

`ifdef SEQ_CHECK_EN
  logic r_seq_err;

  // Sticky flag: counter output disagrees with the predicted sequence.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_seq_err <= 1'b0;
    end else if (((r_state == RUN) || (r_state == DONE)) && (cnt_q != r_shadow)) begin
      r_seq_err <= 1'b1;
    end
  end

  assign seq_err = r_seq_err;
`else
  logic w_unused_cnt_q;
  assign w_unused_cnt_q = ^cnt_q;
  assign seq_err        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_cnt_sched.sv
// Self-checking bench for seq_cnt_sched: a job-level reference model
// (winner, start, steps, final value by repeated table lookup) predicts every
// output each cycle; directed jobs pin literal results, latencies and the
// round-robin order; a randomized phase drives overlapping requesters.
module tb_seq_cnt_sched;

  localparam int NREQ   = 4;
  localparam int STEP_W = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic       cnt_en;
  logic [2:0] cnt_value;
  logic [2:0] cnt_q;
  logic [2:0] q_ff;
  logic       seq_err;
  logic       corrupt;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit         m_busy   = 0;
  int         m_t      = 0;
  int         m_len    = 0;
  int         m_win    = 0;
  int         m_ptr    = 0;
  logic [2:0] m_start  = 0;
  int         m_steps  = 0;
  logic [2:0] m_final  = 0;
  logic [2:0] m_hold   = 0;
  logic [2:0] m_result = 0;
  bit         m_err    = 0;

  seq_cnt_sched_if #(.NREQ(NREQ), .STEP_W(STEP_W)) bus ();

  seq_cnt_sched #(.NREQ(NREQ), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .cnt_en    (cnt_en),
    .cnt_value (cnt_value),
    .cnt_q     (cnt_q),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] nxt(input logic [2:0] v);
    logic [2:0] tbl [8];
    tbl = '{3'd6, 3'd6, 3'd7, 3'd0, 3'd7, 3'd2, 3'd4, 3'd3};
    return tbl[v];
  endfunction

  function automatic logic [2:0] adv(input logic [2:0] v, input int n);
    logic [2:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = nxt(r);
    return r;
  endfunction

  // Physical counter: en high presets q to value asynchronously, else it advances.
  always @(posedge clk) begin
    if (cnt_en) q_ff <= cnt_value;
    else        q_ff <= nxt(q_ff);
  end
  assign cnt_q = (cnt_en ? cnt_value : q_ff) ^ {2'b00, corrupt};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model advanced on each clock edge.
  initial forever begin
    @(posedge clk or posedge clr);
    if (clr) begin
      m_busy = 0; m_ptr = 0; m_hold = 0; m_result = 0; m_err = 0; m_t = 0;
    end else begin
      if (corrupt && m_busy && m_t >= 2) m_err = 1;
      if (m_busy) begin
        if (m_t == m_len) begin
          m_busy   = 0;
          m_hold   = m_final;
          m_result = m_final;
        end else begin
          m_t++;
        end
      end else if (bus.req != 0) begin
        bit found;
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (m_ptr + k) % NREQ;
          if (!found && bus.req[j]) begin
            found = 1;
            m_win = j;
          end
        end
        m_start = bus.start[3*m_win +: 3];
        m_steps = int'(bus.steps[STEP_W*m_win +: STEP_W]);
        m_len   = m_steps + 2;
        m_final = adv(m_start, m_steps);
        m_t     = 1;
        m_busy  = 1;
        m_ptr   = (m_win + 1) % NREQ;
      end
    end
  end

  task automatic compare_now();
    logic [3:0] e_gnt;
    logic       e_done, e_en;
    logic [2:0] e_val, e_q, e_res;
    if (m_busy) begin
      e_gnt  = 4'(1 << m_win);
      e_done = (m_t == m_len);
      e_en   = (m_t == 1) || (m_t == m_len);
      e_val  = (m_t == 1) ? m_start : m_final;
      e_q    = adv(m_start, (m_t >= 2) ? m_t - 2 : 0);
      e_res  = e_done ? m_final : m_result;
    end else begin
      e_gnt  = '0;
      e_done = 1'b0;
      e_en   = 1'b1;
      e_val  = m_hold;
      e_q    = m_hold;
      e_res  = m_result;
    end
    chk("gnt", bus.gnt, e_gnt);
    chk("done", bus.done, e_done);
    chk("result", bus.result, e_res);
    chk("cnt_en", cnt_en, e_en);
    if (e_en) chk("cnt_value", cnt_value, e_val);
    chk("cnt_q", cnt_q, e_q ^ {2'b00, corrupt});
    chk("seq_err", seq_err, m_err);
  endtask

  initial forever begin
    @(negedge clk);
    if (!clr) compare_now();
  end

  task automatic rnd_slot(input int i);
    bus.start[3*i +: 3]           = 3'($urandom_range(0, 7));
    bus.steps[STEP_W*i +: STEP_W] = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
  endtask

  task automatic run_job(input int idx, input logic [2:0] s, input logic [3:0] n,
                         input logic [2:0] exp_res, input int exp_lat, input string nm);
    int cyc;
    bit got;
    @(negedge clk);
    bus.start[3*idx +: 3]           = s;
    bus.steps[STEP_W*idx +: STEP_W] = n;
    bus.req[idx]                    = 1'b1;
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.done) got = 1;
    end
    chk({nm, "_lat"}, cyc, exp_lat);
    chk({nm, "_res"}, bus.result, exp_res);
    bus.req[idx] = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, "_park"}, cnt_value, exp_res);
  endtask

  initial begin
    int exp_ord [6];
    int n, cyc, last, idx;
    logic [3:0] prevg;
    exp_ord = '{0, 1, 2, 3, 0, 1};
    corrupt   = 1'b0;
    clr       = 1'b1;
    bus.req   = '0;
    bus.start = '0;
    bus.steps = '0;
    repeat (3) @(negedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_cnt_en", cnt_en, 1);
    chk("rst_cnt_value", cnt_value, 0);
    chk("rst_result", bus.result, 0);

    run_job(0, 3'd4, 4'd3, 3'd0, 5, "job_4x3");
    run_job(2, 3'd5, 4'd0, 3'd5, 2, "job_5x0");
    run_job(1, 3'd5, 4'd2, 3'd7, 4, "job_5x2");
    run_job(3, 3'd1, 4'd1, 3'd6, 3, "job_1x1");

    // clr in the middle of a job aborts it at once
    @(negedge clk);
    bus.start[2:0] = 3'd3;
    bus.steps[3:0] = 4'd10;
    bus.req[0]     = 1'b1;
    repeat (4) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("abort_gnt", bus.gnt, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_cnt_en", cnt_en, 1);
    chk("abort_cnt_value", cnt_value, 0);
    chk("abort_cnt_q", cnt_q, 0);
    chk("abort_result", bus.result, 0);
    bus.req = '0;
    @(negedge clk);
    #2 clr = 1'b0;

    // round-robin with all four requesting
    @(negedge clk);
    bus.steps = 16'h1111;
    for (int i = 0; i < NREQ; i++) bus.start[3*i +: 3] = 3'($urandom_range(0, 7));
    bus.req = 4'hF;
    n = 0; cyc = 0; last = 0; prevg = '0;
    while (n < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != 0 && prevg == 0) begin
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) idx = i;
        chk("rr_order", idx, exp_ord[n]);
        if (n > 0) chk("rr_gap", cyc - last, 4);
        last = cyc;
        n++;
      end
      prevg = bus.gnt;
    end
    chk("rr_count", n, 6);
    bus.req = '0;
    repeat (8) @(negedge clk);

    // randomized overlapping traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) begin
        #2 clr = 1'b1;
        @(negedge clk);
        #2 clr = 1'b0;
        continue;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (m_busy && m_win == i) begin
          if (m_t == m_len) begin
            if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
            else rnd_slot(i);
          end else begin
            rnd_slot(i);
            if ($urandom_range(0, 7) == 0) bus.req[i] = 1'b0;
          end
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            rnd_slot(i);
            bus.req[i] = 1'b1;
          end
        end
      end
    end
    bus.req = '0;
    repeat (40) @(negedge clk);

`ifdef SEQ_CHECK_EN
    #2 clr = 1'b1;
    @(negedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
    bus.start[2:0] = 3'd0;
    bus.steps[3:0] = 4'd6;
    bus.req[0]     = 1'b1;
    cyc = 0;
    while (!(m_busy && m_t == 3) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("inj_reach_run", cyc < 20, 1);
    #1 corrupt = 1'b1;
    @(negedge clk);
    #1 corrupt = 1'b0;
    chk("inj_err_rise", seq_err, 1);
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    bus.req[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("inj_err_sticky", seq_err, 1);
    #2 clr = 1'b1;
    #1 chk("inj_err_clr", seq_err, 0);
    @(negedge clk);
    #2 clr = 1'b0;
    repeat (3) @(negedge clk);
`else
    chk("err_tied_low", seq_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
